// File: rtl/clk_div_top.sv
// Programmable clock divider configured from a register bus, a UART receiver or an SPI slave.
// Handshake: bus commands are single-cycle strobes sampled at posedge; no valid/ready stalls.
module clk_div_top #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [1:0]            cmd_opt_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic [DATA_WIDTH-1:0] cmd_rdata_o,
  input  logic                  uart_rx_i,
  input  logic                  i2c_scl_i,
  inout  wire                   i2c_sda_io,
  input  logic                  spi_csn_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  div_en_o,
  output logic                  div_clk_o
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_DIV  = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(8'h08);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  logic        ctrl_en;
  logic [15:0] div_n;
  logic        uart_ferr;
  logic [7:0]  uart_byte;

  logic unused_inputs;
  assign unused_inputs = ^{i2c_scl_i, cmd_data_i};
  assign i2c_sda_io    = 1'bz;

  function automatic logic [DATA_WIDTH-1:0] reg_read(
    input logic [ADDR_WIDTH-1:0] a, input logic en, input logic [15:0] n,
    input logic ferr, input logic [7:0] ub);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    case (a)
      A_CTRL: v[0] = en;
      A_DIV:  v[15:0] = n;
      A_STAT: begin
        v[0]    = en;
        v[1]    = ferr;
        v[15:8] = ub;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  // ---------------- bus read port ----------------
  logic [DATA_WIDTH-1:0] bus_rd_val;
  assign bus_rd_val = reg_read(cmd_addr_i, ctrl_en, div_n, uart_ferr, uart_byte);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) cmd_rdata_o <= '0;
    else if (cmd_opt_i == 2'b01) cmd_rdata_o <= bus_rd_val;
  end

  // ---------------- UART receiver ----------------
  logic          rx_s1, rx_s2, rx_s3;
  logic [1:0]    u_state;
  logic [CW-1:0] u_cnt;
  logic [2:0]    u_idx;
  logic [7:0]    u_sh;
  logic          uart_ok, uart_bad;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      u_state  <= U_IDLE;
      u_cnt    <= '0;
      u_idx    <= '0;
      u_sh     <= '0;
      uart_ok  <= 1'b0;
      uart_bad <= 1'b0;
    end else begin
      rx_s1    <= uart_rx_i;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      uart_ok  <= 1'b0;
      uart_bad <= 1'b0;
      case (u_state)
        U_IDLE: if (rx_s3 && !rx_s2) begin
          u_state <= U_START;
          u_cnt   <= '0;
        end
        U_START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (u_cnt == HALF_LAST) begin
            u_cnt   <= '0;
            u_idx   <= '0;
            u_state <= rx_s2 ? U_IDLE : U_DATA;
          end else u_cnt <= u_cnt + 1'b1;
        end
        U_DATA: begin
          if (u_cnt == BIT_LAST) begin
            u_cnt <= '0;
            u_sh  <= {rx_s2, u_sh[7:1]};
            if (u_idx == 3'd7) u_state <= U_STOP;
            else u_idx <= u_idx + 3'd1;
          end else u_cnt <= u_cnt + 1'b1;
        end
        default: begin
          if (u_cnt == BIT_LAST) begin
            u_cnt    <= '0;
            u_state  <= U_IDLE;
            uart_ok  <= rx_s2;
            uart_bad <= !rx_s2;
          end else u_cnt <= u_cnt + 1'b1;
        end
      endcase
    end
  end

  // ---------------- SPI slave (mode 0) ----------------
  logic        csn_s1, csn_s2, sck_s1, sck_s2, sck_s3, mosi_s1, mosi_s2;
  logic [14:0] spi_sh;
  logic [4:0]  spi_cnt;
  logic [7:0]  spi_tx;
  logic        spi_miso_q;
  logic [15:0] spi_word;
  logic        sck_rise, sck_fall, spi_wr;
  logic [DATA_WIDTH-1:0] spi_rd_val;

  assign sck_rise   = sck_s2 && !sck_s3;
  assign sck_fall   = !sck_s2 && sck_s3;
  assign spi_word   = {spi_sh, mosi_s2};
  assign spi_wr     = !csn_s2 && sck_rise && (spi_cnt == 5'd15) && spi_word[15];
  assign spi_rd_val = reg_read(ADDR_WIDTH'(spi_word[6:0]), ctrl_en, div_n, uart_ferr, uart_byte);
  assign spi_miso_o = spi_miso_q && !spi_csn_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      csn_s1     <= 1'b1;
      csn_s2     <= 1'b1;
      sck_s1     <= 1'b0;
      sck_s2     <= 1'b0;
      sck_s3     <= 1'b0;
      mosi_s1    <= 1'b0;
      mosi_s2    <= 1'b0;
      spi_sh     <= '0;
      spi_cnt    <= '0;
      spi_tx     <= '0;
      spi_miso_q <= 1'b0;
    end else begin
      csn_s1  <= spi_csn_i;
      csn_s2  <= csn_s1;
      sck_s1  <= spi_clk_i;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      mosi_s1 <= spi_mosi_i;
      mosi_s2 <= mosi_s1;
      if (csn_s2) begin
        spi_cnt    <= '0;
        spi_miso_q <= 1'b0;
      end else begin
        if (sck_rise && spi_cnt != 5'd16) begin
          spi_sh  <= spi_word[14:0];
          spi_cnt <= spi_cnt + 5'd1;
          // Header complete after 8 bits: capture the read byte for the data phase.
          if (spi_cnt == 5'd7) spi_tx <= spi_rd_val[7:0];
        end
        if (sck_fall && spi_cnt >= 5'd8 && spi_cnt <= 5'd15) begin
          spi_miso_q <= spi_tx[7];
          spi_tx     <= {spi_tx[6:0], 1'b0};
        end
      end
    end
  end

  // ---------------- register file: bus beats SPI beats UART ----------------
  logic                  bus_wr;
  logic [ADDR_WIDTH-1:0] spi_addr;
  assign bus_wr   = (cmd_opt_i == 2'b10);
  assign spi_addr = ADDR_WIDTH'(spi_word[14:8]);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en   <= 1'b0;
      div_n     <= 16'd2;
      uart_ferr <= 1'b0;
      uart_byte <= '0;
    end else begin
      if (bus_wr) begin
        if (cmd_addr_i == A_CTRL) begin
          ctrl_en   <= cmd_data_i[0];
          uart_ferr <= 1'b0;
        end else if (cmd_addr_i == A_DIV) div_n <= cmd_data_i[15:0];
      end else if (spi_wr) begin
        if (spi_addr == A_CTRL) begin
          ctrl_en   <= spi_word[0];
          uart_ferr <= 1'b0;
        end else if (spi_addr == A_DIV) div_n <= {8'b0, spi_word[7:0]};
      end else if (uart_ok) begin
        uart_byte <= u_sh;
        ctrl_en   <= u_sh[7];
        div_n     <= {9'b0, u_sh[6:0]};
      end
      if (uart_bad) uart_ferr <= 1'b1;
    end
  end

  // ---------------- divider ----------------
  logic [15:0] eff_n, nl, cnt;
  assign eff_n = (div_n < 16'd2) ? 16'd2 : div_n;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_en_o  <= 1'b0;
      div_clk_o <= 1'b0;
      nl        <= 16'd2;
      cnt       <= '0;
    end else begin
      div_en_o <= ctrl_en;
      if (!ctrl_en) begin
        cnt       <= '0;
        div_clk_o <= 1'b0;
      end else if (!div_en_o) begin
        nl  <= eff_n;
        cnt <= '0;
      end else begin
        div_clk_o <= (cnt < (nl >> 1));
        // The divisor is only re-latched at the wrap, so periods never get cut short.
        if (cnt == nl - 16'd1) begin
          cnt <= '0;
          nl  <= eff_n;
        end else cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_top.sv
// Directed-plus-random bench for clk_div_top against a register-level reference model.
module tb_clk_div_top;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd_opt_i;
  logic [7:0]  cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic [31:0] cmd_rdata_o;
  logic        uart_rx_i;
  logic        i2c_scl_i;
  wire         i2c_sda_io;
  logic        spi_csn_i, spi_clk_i, spi_mosi_i;
  logic        spi_miso_o, div_en_o, div_clk_o;

  int n_cmp = 0;
  int n_err = 0;

  // reference register model
  logic        m_en;
  logic [15:0] m_div;
  logic        m_ferr;
  logic [7:0]  m_byte;

  always #5 clk_i = ~clk_i;

  clk_div_top #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CLKS_PER_BIT(16)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .cmd_opt_i(cmd_opt_i), .cmd_addr_i(cmd_addr_i),
    .cmd_data_i(cmd_data_i), .cmd_rdata_o(cmd_rdata_o), .uart_rx_i(uart_rx_i),
    .i2c_scl_i(i2c_scl_i), .i2c_sda_io(i2c_sda_io), .spi_csn_i(spi_csn_i),
    .spi_clk_i(spi_clk_i), .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o),
    .div_en_o(div_en_o), .div_clk_o(div_clk_o)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input logic [15:0] n);
    return (n < 16'd2) ? 2 : int'(n);
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_div = 16'd2; m_ferr = 1'b0; m_byte = 8'h00;
  endtask

  // all driver tasks start and end just after a falling clock edge
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    cmd_opt_i = 2'b10; cmd_addr_i = a; cmd_data_i = d;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_opt_i = 2'b00;
  endtask

  task automatic bus_read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    cmd_opt_i = 2'b01; cmd_addr_i = a;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_opt_i = 2'b00;
    check(tag, cmd_rdata_o, exp);
  endtask

  task automatic check_regs(input string tag);
    bus_read_check({tag, "_ctrl"}, 8'h00, {31'b0, m_en});
    bus_read_check({tag, "_status"}, 8'h08, {16'b0, m_byte, 6'b0, m_ferr, m_en});
    bus_read_check({tag, "_div"}, 8'h04, {16'b0, m_div});
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    repeat (16) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (16) @(negedge clk_i);
    end
    uart_rx_i = stop;
    repeat (16) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (32) @(negedge clk_i);
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nbits, input bit clash,
                           output logic [7:0] rx);
    rx = '0;
    spi_csn_i = 1'b0;
    repeat (8) @(negedge clk_i);
    for (int i = 15; i > 15 - nbits; i--) begin
      spi_mosi_i = w[i];
      repeat (6) @(negedge clk_i);
      if (i < 8) rx[i] = spi_miso_o;
      spi_clk_i = 1'b1;
      if (clash && i == 0) begin
        cmd_opt_i = 2'b10; cmd_addr_i = 8'h04; cmd_data_i = 32'd8;
      end
      repeat (6) @(negedge clk_i);
      cmd_opt_i = 2'b00;
      spi_clk_i = 1'b0;
    end
    repeat (6) @(negedge clk_i);
    spi_csn_i = 1'b1;
    spi_mosi_i = 1'b0;
    repeat (8) @(negedge clk_i);
  endtask

  // Measures one full divided-clock period starting at the next rising edge.
  // Optionally issues a DIV write during the first high cycle of that period.
  task automatic measure(input string tag, input int exp_n, input bit do_wr, input logic [15:0] wr_val);
    int guard, hi, lo;
    guard = 0;
    while (div_clk_o !== 1'b0 && guard < 200) begin @(negedge clk_i); guard++; end
    while (div_clk_o !== 1'b1 && guard < 200) begin @(negedge clk_i); guard++; end
    check({tag, "_rise_timeout"}, 32'(guard >= 200), 32'd0);
    if (guard >= 200) return;
    if (do_wr) begin
      cmd_opt_i = 2'b10; cmd_addr_i = 8'h04; cmd_data_i = {16'b0, wr_val};
    end
    hi = 0;
    while (div_clk_o === 1'b1 && hi < 200) begin
      hi++;
      @(negedge clk_i);
      cmd_opt_i = 2'b00;
    end
    lo = 0;
    while (div_clk_o === 1'b0 && lo < 200) begin lo++; @(negedge clk_i); end
    check({tag, "_high"}, 32'(hi), 32'(exp_n / 2));
    check({tag, "_low"}, 32'(lo), 32'(exp_n - exp_n / 2));
  endtask

  initial begin
    logic [7:0]  rx, b;
    logic [15:0] n;
    int          g;

    rst_n = 1'b0; cmd_opt_i = 2'b00; cmd_addr_i = '0; cmd_data_i = '0;
    uart_rx_i = 1'b1; i2c_scl_i = 1'b0; spi_csn_i = 1'b1; spi_clk_i = 1'b0; spi_mosi_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);

    // 1. reset state
    check("rst_div_en", {31'b0, div_en_o}, 32'd0);
    check("rst_div_clk", {31'b0, div_clk_o}, 32'd0);
    check("rst_rdata", cmd_rdata_o, 32'd0);
    check("rst_miso", {31'b0, spi_miso_o}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);
    check_regs("reset");
    bus_read_check("unmapped_rd", 8'h0C, 32'd0);
    bus_write(8'h0C, 32'hFFFF_FFFF);
    check_regs("unmapped_wr");

    // 2. DIV=4, enable, first-high latency
    bus_write(8'h04, 32'd4); m_div = 16'd4;
    bus_write(8'h00, 32'd1); m_en = 1'b1;
    g = 0;
    do begin @(negedge clk_i); g++; end while (div_en_o !== 1'b1 && g < 10);
    check("en_rise_timeout", 32'(g >= 10), 32'd0);
    check("clk_low_at_en_rise", {31'b0, div_clk_o}, 32'd0);
    @(negedge clk_i);
    check("first_high", {31'b0, div_clk_o}, 32'd1);
    measure("div4", 4, 1'b0, 16'd0);
    bus_read_check("status_en", 8'h08, {16'b0, m_byte, 6'b0, m_ferr, m_en});

    // 3. DIV=5, then DIV=2 written mid-period
    bus_write(8'h04, 32'd5); m_div = 16'd5;
    repeat (12) @(negedge clk_i);
    measure("div5", 5, 1'b0, 16'd0);
    measure("div5_midwr", 5, 1'b1, 16'd2); m_div = 16'd2;
    measure("div2", 2, 1'b0, 16'd0);

    for (int k = 0; k < 4; k++) begin
      n = 16'($urandom_range(0, 11));
      bus_write(8'h04, {16'b0, n}); m_div = n;
      repeat (30) @(negedge clk_i);
      bus_read_check("rand_div_rd", 8'h04, {16'b0, m_div});
      measure("rand_div", eff(n), 1'b0, 16'd0);
    end

    // 4. UART config
    uart_send(8'h83, 1'b1);
    m_byte = 8'h83; m_en = 1'b1; m_div = 16'd3;
    check_regs("uart_83");
    measure("uart_div3", 3, 1'b0, 16'd0);
    b = 8'($urandom_range(0, 255));
    uart_send(b, 1'b0); m_ferr = 1'b1;
    check_regs("uart_badstop");
    b = 8'($urandom_range(0, 255));
    uart_send(b, 1'b1);
    m_byte = b; m_en = b[7]; m_div = {9'b0, b[6:0]};
    check_regs("uart_rand");
    bus_write(8'h00, 32'd1); m_en = 1'b1; m_ferr = 1'b0;
    check_regs("ferr_clear");

    // 5. SPI write/read and abort
    spi_frame(16'h8406, 16, 1'b0, rx); m_div = 16'd6;
    spi_frame(16'h0400, 16, 1'b0, rx);
    check("spi_rd_div", {24'b0, rx}, 32'h06);
    check_regs("spi_wr6");
    measure("spi_div6", 6, 1'b0, 16'd0);
    spi_frame(16'h8409, 10, 1'b0, rx);
    check_regs("spi_abort");
    check("miso_idle", {31'b0, spi_miso_o}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom_range(0, 20));
      spi_frame({8'h84, b}, 16, 1'b0, rx); m_div = {8'b0, b};
      spi_frame(16'h0400, 16, 1'b0, rx);
      check("spi_rand_rd", {24'b0, rx}, {24'b0, b});
      measure("spi_rand_div", eff(m_div), 1'b0, 16'd0);
    end
    spi_frame(16'h0000, 16, 1'b0, rx);
    check("spi_rd_ctrl", {24'b0, rx}, {31'b0, m_en});

    // 6. bus and SPI write DIV in the same cycle; then reset while dividing
    spi_frame(16'h8406, 16, 1'b1, rx); m_div = 16'd8;
    check_regs("clash");
    measure("clash_div8", 8, 1'b0, 16'd0);
    g = 0;
    while (div_clk_o !== 1'b1 && g < 50) begin @(negedge clk_i); g++; end
    check("pre_rst_clk_high", {31'b0, div_clk_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_div_en", {31'b0, div_en_o}, 32'd0);
    check("midrst_div_clk", {31'b0, div_clk_o}, 32'd0);
    check("midrst_rdata", cmd_rdata_o, 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    check_regs("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
